// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_XOR  = 3'b110,
    OP_XNOR = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between an ALU client and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 flag_zero;
  logic                 flag_carry;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_carry
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_carry
  );
endinterface

// File: rtl/alu_shift_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_shift_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  // done/product reflect the step being taken this cycle, so the final
  // partial product is usable on the same edge that retires it.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative multiply, held result until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  state_t             state;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] alu_res, mul_prod;
  logic               alu_c, mul_start, mul_done;

  assign mul_start = (state == ST_IDLE) && bus.in_valid && (opcode_t'(bus.opcode) == OP_MUL);

  alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // diff[WIDTH] is the borrow: set exactly when a < b.
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode_t'(bus.opcode))
      OP_ADD:  begin alu_res = {{(WIDTH-1){1'b0}}, sum};  alu_c = sum[WIDTH];  end
      OP_SUB:  begin alu_res = {{WIDTH{1'b0}}, diff[WIDTH-1:0]}; alu_c = diff[WIDTH]; end
      OP_AND:  alu_res = {{WIDTH{1'b0}}, bus.a & bus.b};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, bus.a | bus.b};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~bus.a};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.result     <= '0;
      bus.flag_zero  <= 1'b0;
      bus.flag_carry <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          bus.in_ready <= 1'b0;
          if (opcode_t'(bus.opcode) == OP_MUL) begin
            state <= ST_MUL;
          end else begin
            bus.result     <= alu_res;
            bus.flag_zero  <= (alu_res == '0);
            bus.flag_carry <= alu_c;
            bus.out_valid  <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_MUL: if (mul_done) begin
          bus.result     <= mul_prod;
          bus.flag_zero  <= (mul_prod == '0);
          bus.flag_carry <= 1'b0;
          bus.out_valid  <= 1'b1;
          state          <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=8, plus backpressure and mid-multiply reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency, check outputs, then complete the handshake.
  task automatic run_op(input vec_t v, input string nm);
    int  n;
    int  lat;
    int  exp_lat;
    bit  rdy_bad;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.opcode   = v.op;
    tick();
    // scramble inputs after the accept edge to prove they were captured
    bus.in_valid = 1'b0;
    bus.a        = ~v.a;
    bus.b        = ~v.b;
    bus.opcode   = 3'b000;
    exp_lat      = (v.op == 3'b010) ? 9 : 1;
    lat          = 1;
    rdy_bad      = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_bad = 1'b1;
      tick();
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy_ready"}, 32'(rdy_bad), 32'd0);
    chk({nm, " result"}, 32'(bus.result), 32'(v.res));
    chk({nm, " carry"}, 32'(bus.flag_carry), 32'(v.c));
    chk({nm, " zero"}, 32'(bus.flag_zero), 32'(v.z));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{3'b000, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{3'b000, 8'd255, 8'd1,   16'h0100, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{3'b001, 8'd200, 8'd100, 16'h0064, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0};
    vecs[7]  = '{3'b010, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{3'b010, 8'd12,  8'd13,  16'h009C, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 8'h0F,  8'h55,  16'h00F0, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 8'hAA,  8'hFF,  16'h0055, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 8'h0F,  8'h0F,  16'h00FF, 1'b0, 1'b0};
    vecs[14] = '{3'b110, 8'h5A,  8'h5A,  16'h0000, 1'b0, 1'b1};
    vecs[15] = '{3'b101, 8'hFF,  8'h00,  16'h0000, 1'b0, 1'b1};

    repeat (3) tick();
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", 32'(bus.result), 32'd0);
    chk("rst zero", 32'(bus.flag_zero), 32'd0);
    chk("rst carry", 32'(bus.flag_carry), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // out_ready with nothing pending must not disturb the idle state
    bus.out_ready = 1'b1;
    repeat (2) tick();
    bus.out_ready = 1'b0;
    chk("idle out_ready valid", 32'(bus.out_valid), 32'd0);
    chk("idle out_ready ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles while stray requests are ignored
    bus.in_valid = 1'b1;
    bus.a        = 8'd200;
    bus.b        = 8'd100;
    bus.opcode   = 3'b000;
    tick();
    bus.in_valid = 1'b0;
    chk("bp first valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.opcode   = 3'b001;
      bus.a        = 8'd1;
      bus.b        = 8'd2;
      tick();
      chk($sformatf("bp%0d valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d result", i), 32'(bus.result), 32'h012C);
      chk($sformatf("bp%0d carry", i), 32'(bus.flag_carry), 32'd1);
      chk($sformatf("bp%0d zero", i), 32'(bus.flag_zero), 32'd0);
      chk($sformatf("bp%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp release valid", 32'(bus.out_valid), 32'd0);
    chk("bp release ready", 32'(bus.in_ready), 32'd1);
    v = '{3'b000, 8'd255, 8'd1, 16'h0100, 1'b1, 1'b0};
    run_op(v, "bp resume");

    // Reset in the 4th multiply cycle abandons the product
    bus.in_valid = 1'b1;
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    bus.opcode   = 3'b010;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("mulrst busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mulrst valid", 32'(bus.out_valid), 32'd0);
    chk("mulrst result", 32'(bus.result), 32'd0);
    chk("mulrst carry", 32'(bus.flag_carry), 32'd0);
    chk("mulrst zero", 32'(bus.flag_zero), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    begin
      bit stale;
      stale = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.out_valid) stale = 1'b1;
      end
      chk("mulrst no stale", 32'(stale), 32'd0);
    end
    chk("mulrst ready", 32'(bus.in_ready), 32'd1);
    v = '{3'b000, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0};
    run_op(v, "mulrst add");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have in_valid  input  1  operand/opcode present.
REQ-005 SHALL have in_ready  output  1  block accepts a new operation.
REQ-006 SHALL have a, b  input  WIDTH each  operands, unsigned.
REQ-007 SHALL have opcode  input  3  000 add, 001 sub, 010 mul, 011 and, 100 or, 101 not(a), 110 xor, 111 xnor.
REQ-008 SHALL have out_valid  output  1  result present.
REQ-009 SHALL have out_ready  input  1  consumer takes result.
REQ-010 SHALL have result  output  2*WIDTH  registered result.
REQ-011 SHALL have flag_zero, flag_carry  output  1 each  result==0; carry-out (add) or borrow (sub).

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-013 SHALL accept an operation on a clk edge where in_valid & in_ready; a, b, opcode captured at that edge; inputs ignored at all other times.
REQ-014 Non-mul accept SHALL register result and flags and enter DONE; out_valid high on the next cycle (latency 1).
REQ-015 Mul accept SHALL load operands, clear a counter and enter MUL; one shift-add step per cycle for exactly WIDTH cycles, then DONE (out_valid latency WIDTH+1 cycles after accept).
REQ-016 In DONE, out_valid SHALL be 1 and result/flags SHALL be held stable until out_ready=1; on that edge return to IDLE, out_valid drops next cycle.
REQ-017 Throughput: at most one operation in flight; no new accept until the cycle after the DONE->IDLE handshake.
REQ-018 add: result = zero-extended a+b (full WIDTH+1 bits); flag_carry = sum bit WIDTH.
REQ-019 sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH, upper bits 0; flag_carry = 1 iff a<b.
REQ-020 mul: result = full 2*WIDTH unsigned product; flag_carry = 0.
REQ-021 Logic ops and not(a): bitwise on WIDTH bits, zero-extended to 2*WIDTH; flag_carry = 0.
REQ-022 flag_zero SHALL be 1 iff the full 2*WIDTH result is zero.
REQ-023 out_ready while out_valid=0 SHALL have no effect; in_valid during MUL/DONE SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, clear counter, result=0, flag_zero=0, flag_carry=0, out_valid=0; in_ready=1 once reset deasserts.
REQ-025 Reset during MUL or DONE SHALL abandon the operation; no out_valid SHALL be produced for it.

Structure
REQ-026 Opcode constants and FSM state encoding SHALL live in shared package alu_pkg.
REQ-027 The iterative multiplier SHALL be sub-module alu_shift_mul (start, done, WIDTH-parameterised); all other ops inline.

Verification (WIDTH=8)
REQ-028 add a=200 b=100 -> result 0x012C, flag_carry=1, flag_zero=0, out_valid 1 cycle after accept.
REQ-029 sub a=5 b=7 -> result 0x00FE, flag_carry=1; sub a=9 b=9 -> result 0x0000, flag_zero=1.
REQ-030 mul a=255 b=255 -> result 0xFE01, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-031 xnor a=0x0F b=0x0F -> 0x00FF; not a=0x0F -> 0x00F0.
REQ-032 Backpressure: out_ready low 5 cycles after result -> result, flags and out_valid stable; in_valid pulses ignored; accept resumes after handshake.
REQ-033 rst_n low in 4th MUL cycle -> all outputs reset immediately; next add 1+1 -> 0x0002 with no stale result emitted.
